// File: rtl/imem_boot_loader_if.sv
// Boot loader bus bundle: inbound byte stream, instruction RAM write port, CPU hold and status.
// The slave modport is the loader; the master modport is the stream source / RAM side.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_W = 11
);
  logic [7:0]        s_byte;
  logic              s_valid;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    output s_byte, s_valid,
    input  s_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );

  modport slave (
    input  s_byte, s_valid,
    output s_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader: 32-bit LE count, N LE payload words, XOR checksum byte.
// Writes words to instruction RAM at consecutive addresses, then releases the CPU.
module imem_boot_loader #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned MAX_WORDS = 2048
) (
  input  logic             clk_in,
  input  logic             reset,
  imem_boot_loader_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       len_q, len_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [7:0]        xsum_q, xsum_d;
  logic [31:0]       asm_q, asm_d;
  logic              s_ready_q, s_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              take;
  logic [31:0]       len_full;

  assign take     = bus.s_valid && s_ready_q;
  // Bytes arrive LSB first, so shifting in from the top leaves byte 0 at [7:0].
  assign len_full = {bus.s_byte, len_q[31:8]};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    wcnt_d      = wcnt_q;
    xsum_d      = xsum_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_HDR: begin
        if (take) begin
          len_d = len_full;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (len_full > 32'(MAX_WORDS)) state_d = S_ERROR;
            else if (len_full == '0)       state_d = S_CHK;
            else                           state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (take) begin
          asm_d  = {bus.s_byte, asm_q[31:8]};
          xsum_d = xsum_q ^ bus.s_byte;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ADDR_W'(wcnt_q);
            mem_wdata_d = asm_d;
            wcnt_d      = wcnt_q + CNT_W'(1);
            if (32'(wcnt_d) == len_q) state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (take) state_d = (bus.s_byte == xsum_q) ? S_DONE : S_ERROR;
      end
      default: ;
    endcase

    // Registered outputs are derived from the next state so they line up with it.
    s_ready_d  = (state_d == S_HDR || state_d == S_LOAD || state_d == S_CHK) && !mem_we_d;
    cpu_hold_d = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERROR);
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q     <= S_HDR;
      idx_q       <= '0;
      len_q       <= '0;
      wcnt_q      <= '0;
      xsum_q      <= '0;
      asm_q       <= '0;
      s_ready_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      wcnt_q      <= wcnt_d;
      xsum_q      <= xsum_d;
      asm_q       <= asm_d;
      s_ready_q   <= s_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
endmodule
